button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The parameter list SHALL be exactly as follows.
- DEBOUNCE_CYCLES, default 500000: consecutive synchronized samples needed to accept a level change; minimum 2.
- LONG_PRESS_CYCLES, default 50000000: cycles in PRESSED before long_press fires; minimum 1.
REQ-002 The port list SHALL be exactly as follows.
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- btn_raw  input  1  asynchronous mechanical button, active-high.
- btn_level  output  1  debounced level; drives the downstream mode-rotator button input.
- press_pulse  output  1  one-cycle strobe on accepted press.
- release_pulse  output  1  one-cycle strobe on accepted release.
- long_press  output  1  one-cycle strobe on long hold.
REQ-003 All outputs SHALL be registered, with no combinational path from btn_raw.

Function
REQ-004 btn_raw SHALL pass through a 2-flop synchronizer; only the second flop's output (sync) feeds the FSM.
REQ-005 The FSM SHALL have exactly four states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-006 IDLE: sync=1 -> PRESS_WAIT with debounce count=1; else stay; btn_level=0.
REQ-007 PRESS_WAIT:
- sync=0 -> IDLE, count cleared.
- sync=1 and count==DEBOUNCE_CYCLES-1 -> PRESSED.
- otherwise count+1.
REQ-008 On PRESS_WAIT->PRESSED, btn_level SHALL go 1 and press_pulse SHALL be 1 for exactly that one cycle.
REQ-009 PRESSED: sync=0 -> RELEASE_WAIT with count=1; btn_level holds 1.
REQ-010 RELEASE_WAIT:
- sync=1 -> PRESSED, btn_level stays 1, no pulses.
- sync=0 and count==DEBOUNCE_CYCLES-1 -> IDLE, btn_level=0, release_pulse high one cycle.
- otherwise count+1.
REQ-011 Latency: with btn_raw stable from the first edge that samples the new value (edge 1), the btn_level change and strobe SHALL be visible after edge DEBOUNCE_CYCLES+2.
REQ-012 The debounce counter SHALL be $clog2(DEBOUNCE_CYCLES)+1 bits wide and SHALL never wrap.
REQ-013 At most one of press_pulse and release_pulse SHALL be high in any cycle.
REQ-014 A fresh press SHALL require a return to IDLE first; bounce in RELEASE_WAIT never regenerates press_pulse.

Reset
REQ-015 While rst=0, the following SHALL hold: state=IDLE; synchronizer flops, counters and all outputs 0.
REQ-016 Reset asserted mid-operation (any state) SHALL discard progress.
REQ-017 After reset release, a held button SHALL need a full DEBOUNCE_CYCLES+2 edges to register as a press.

Configuration
REQ-018 Macro BUTTON_LONG_PRESS_EN defined: a hold counter ($clog2(LONG_PRESS_CYCLES)+1 bits) SHALL operate as follows.
- Cleared on entry to PRESSED from PRESS_WAIT.
- Increments each cycle in PRESSED.
- Frozen in RELEASE_WAIT.
- Saturates at LONG_PRESS_CYCLES.
REQ-019 With the macro defined, long_press SHALL be high for exactly one cycle when the hold counter reaches LONG_PRESS_CYCLES.
- At most once per accepted press.
- The bounce path RELEASE_WAIT->PRESSED does not re-arm it.
REQ-020 Macro undefined: the long_press port SHALL remain present and tied 0, and no hold counter logic SHALL be present.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20)
REQ-021 The bench SHALL cover the following directed scenarios.
- Clean press: btn_raw 0->1 held 12 cycles -> btn_level 1 after edge 6; press_pulse single cycle at edge 6.
- Press bounce: btn_raw 1 for 3 cycles, 0 for 1, 1 for 3, then 0 -> btn_level stays 0; no strobes.
- Release bounce: while PRESSED, btn_raw 0 for 2 cycles then 1 -> btn_level stays 1; no release_pulse. Then 0 held 6 cycles -> btn_level 0 and release_pulse single cycle.
- Long press (macro defined): btn_raw held 40 cycles -> press_pulse at edge 6, long_press single cycle at edge 26, nothing further. Same stimulus with macro undefined -> long_press constant 0.
- Reset mid-PRESS_WAIT: rst=0 at edge 4 for 2 cycles, btn_raw held 1 -> all outputs 0 during reset; press_pulse 6 edges after the first edge following release.
- Back-to-back: two clean presses separated by 8 low cycles -> exactly two press_pulse and two release_pulse; never coincident.

Source files
------------

// File: rtl/button_conditioner.sv
// Button conditioner: 2-flop synchronizer, debounce FSM, edge strobes.
// Define BUTTON_LONG_PRESS_EN to build the long-hold detector.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES   = 500000,
  parameter int unsigned LONG_PRESS_CYCLES = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  if (DEBOUNCE_CYCLES < 2) begin : g_chk_db
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if (LONG_PRESS_CYCLES < 1) begin : g_chk_lp
    $error("LONG_PRESS_CYCLES must be at least 1");
  end

  logic          meta_q;
  logic          sync_q;
  state_e        state_q;
  state_e        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          level_q;
  logic          level_d;
  logic          press_q;
  logic          press_d;
  logic          rel_q;
  logic          rel_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= btn_raw;
      sync_q <= meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (sync_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!sync_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      RELEASE_WAIT: begin
        if (sync_q) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
    endcase
  end

  // Outputs are decoded from the transition and registered on the same edge.
  always_comb begin
    level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    press_d = (state_q == PRESS_WAIT) && (state_d == PRESSED);
    rel_d   = (state_q == RELEASE_WAIT) && (state_d == IDLE);
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;

`ifdef BUTTON_LONG_PRESS_EN
  localparam int unsigned HW = $clog2(LONG_PRESS_CYCLES) + 1;
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

  logic [HW-1:0] hold_q;
  logic [HW-1:0] hold_d;
  logic          long_q;
  logic          long_d;

  // Only a fresh press clears the hold count; bounce back into PRESSED resumes it.
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (press_d) begin
      hold_d = '0;
    end else if (state_q == PRESSED && hold_q != HOLD_MAX) begin
      hold_d = hold_q + HOLD_ONE;
      long_d = (hold_q == HOLD_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign long_press = long_q;
`else
  assign long_press = 1'b0;
`endif

  a_strobe_excl: assert property (
    @(posedge clk) disable iff (!rst) !(press_pulse && release_pulse)
  );

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20).
// Directed table, scenario sequences and random stimulus against a run-length model.
module tb_button_conditioner;

  localparam int DB = 4;
  localparam int LP = 20;
  localparam logic LP_EN =
`ifdef BUTTON_LONG_PRESS_EN
    1'b1;
`else
    1'b0;
`endif

  logic clk;
  logic rst;
  logic btn_raw;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic long_press;

  button_conditioner #(
    .DEBOUNCE_CYCLES  (DB),
    .LONG_PRESS_CYCLES(LP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_raw      (btn_raw),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_press   (long_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;
  int cp;
  int cr;
  int cl;
  int clv;

  // Model: level flips once DB consecutive synchronized samples disagree with it.
  logic hist[$];
  logic m_level;
  logic m_press;
  logic m_rel;
  logic m_long;
  logic m_last_s;
  int   m_run;
  int   m_hold;

  typedef struct packed {
    logic raw;
    logic level;
    logic press;
    logic rel;
  } vec_t;

  vec_t tv [20];

  function automatic void chk(input string name,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    hist.delete();
    m_level  = 1'b0;
    m_press  = 1'b0;
    m_rel    = 1'b0;
    m_long   = 1'b0;
    m_last_s = 1'b0;
    m_run    = 0;
    m_hold   = 0;
  endfunction

  function automatic void model_edge(input logic raw, input logic rstn);
    logic s;
    if (!rstn) begin
      model_reset();
      return;
    end
    s = (hist.size() >= 2) ? hist[hist.size()-2] : 1'b0;
    hist.push_back(raw);
    if (hist.size() > 2) void'(hist.pop_front());
    m_press = 1'b0;
    m_rel   = 1'b0;
    m_long  = 1'b0;
    if (m_level && m_last_s && m_hold < LP) begin
      m_hold++;
      if (m_hold == LP) m_long = 1'b1;
    end
    m_run = (s != m_level) ? m_run + 1 : 0;
    if (m_run == DB) begin
      m_level = !m_level;
      m_run   = 0;
      m_press = m_level;
      m_rel   = !m_level;
      if (m_level) m_hold = 0;
    end
    m_last_s = s;
  endfunction

  task automatic clr();
    cp  = 0;
    cr  = 0;
    cl  = 0;
    clv = 0;
  endtask

  task automatic step(input logic raw, input logic rstn);
    btn_raw = raw;
    rst     = rstn;
    if (!rstn) begin
      #1;
      chk("async_rst_level", btn_level, 0);
      chk("async_rst_press", press_pulse, 0);
      chk("async_rst_release", release_pulse, 0);
      chk("async_rst_long", long_press, 0);
    end
    @(posedge clk);
    model_edge(raw, rstn);
    #1;
    chk("model_level", btn_level, m_level);
    chk("model_press", press_pulse, m_press);
    chk("model_release", release_pulse, m_rel);
    chk("model_long", long_press, LP_EN ? m_long : 1'b0);
    chk("strobe_excl", press_pulse & release_pulse, 0);
    cp  += int'(press_pulse);
    cr  += int'(release_pulse);
    cl  += int'(long_press);
    clv += int'(btn_level);
  endtask

  task automatic rst_then_press(input string tag);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    clr();
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 1'b1);
      if (k == 5) chk({tag, "_lvl5"}, btn_level, 0);
      if (k == 6) chk({tag, "_press6"}, press_pulse, 1);
    end
    chk({tag, "_npress"}, cp, 1);
    repeat (8) step(1'b0, 1'b1);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    clr();
    model_reset();
    tv = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000,
           4'b1110, 4'b1100, 4'b1100, 4'b1100, 4'b1100,
           4'b1100, 4'b1100, 4'b0100, 4'b0100, 4'b0100,
           4'b0100, 4'b0100, 4'b0001, 4'b0000, 4'b0000};
    rst     = 1'b1;
    btn_raw = 1'b0;
    #2;
    repeat (3) step(1'b0, 1'b0);
    repeat (6) step(1'b0, 1'b1);

    // clean press and release
    for (int i = 0; i < 20; i++) begin
      step(tv[i].raw, 1'b1);
      chk($sformatf("tv%0d_level", i), btn_level, tv[i].level);
      chk($sformatf("tv%0d_press", i), press_pulse, tv[i].press);
      chk($sformatf("tv%0d_release", i), release_pulse, tv[i].rel);
    end
    repeat (4) step(1'b0, 1'b1);

    // press bounce
    clr();
    for (int i = 0; i < 17; i++) step((i < 3) || (i >= 4 && i < 7), 1'b1);
    chk("pbounce_level", clv, 0);
    chk("pbounce_press", cp, 0);
    chk("pbounce_release", cr, 0);

    // release bounce
    repeat (8) step(1'b1, 1'b1);
    chk("rbounce_pressed", btn_level, 1);
    clr();
    repeat (2) step(1'b0, 1'b1);
    repeat (6) step(1'b1, 1'b1);
    chk("rbounce_level", clv, 8);
    chk("rbounce_strobes", cp + cr, 0);
    clr();
    for (int k = 1; k <= 6; k++) begin
      step(1'b0, 1'b1);
      if (k == 5) chk("rel_lvl5", btn_level, 1);
      if (k == 6) chk("rel_lvl6", btn_level, 0);
      if (k == 6) chk("rel_pulse6", release_pulse, 1);
    end
    chk("rel_count", cr, 1);
    repeat (4) step(1'b0, 1'b1);

    // long press, then reset while PRESSED
    clr();
    for (int k = 1; k <= 40; k++) begin
      step(1'b1, 1'b1);
      if (k == 6) chk("long_press6", press_pulse, 1);
      if (k == 26) chk("long_edge26", long_press, LP_EN);
    end
    chk("long_npress", cp, 1);
    chk("long_count", cl, LP_EN ? 1 : 0);
    rst_then_press("rst_pressed");

    // reset mid PRESS_WAIT
    repeat (3) step(1'b1, 1'b1);
    rst_then_press("rst_pwait");

    // back-to-back presses
    clr();
    repeat (2) begin
      repeat (8) step(1'b1, 1'b1);
      repeat (8) step(1'b0, 1'b1);
    end
    chk("b2b_press", cp, 2);
    chk("b2b_release", cr, 2);

    // random bouncy stimulus with occasional resets
    begin
      int   left;
      logic lvl;
      left = 0;
      lvl  = 1'b0;
      for (int i = 0; i < 2500; i++) begin
        if (left == 0) begin
          lvl  = 1'($urandom_range(0, 1));
          left = ($urandom_range(0, 9) == 0) ? int'($urandom_range(20, 40))
                                             : int'($urandom_range(1, 9));
        end
        left--;
        step(lvl, ($urandom_range(0, 299) != 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
